// File: rtl/line_write_combiner_if.sv
// Store-side and memory-side handshake bundle for the line write combiner.
interface line_write_combiner_if;
  logic         cpu_write;
  logic [15:0]  cpu_addr;
  logic [15:0]  cpu_wdata;
  logic [1:0]   cpu_wmask;
  logic         flush_req;
  logic         cpu_resp;
  logic         busy;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_byte_enable;
  logic         mem_resp;
  logic         flush_done;

  modport master (
    output cpu_write, cpu_addr, cpu_wdata, cpu_wmask, flush_req, mem_resp,
    input  cpu_resp, busy, mem_write, mem_address, mem_wdata, mem_byte_enable, flush_done
  );

  modport slave (
    input  cpu_write, cpu_addr, cpu_wdata, cpu_wmask, flush_req, mem_resp,
    output cpu_resp, busy, mem_write, mem_address, mem_wdata, mem_byte_enable, flush_done
  );
endinterface

// File: rtl/line_write_combiner.sv
// Merges 16-bit stores into one 128-bit line with byte-valid tracking and
// drains it to memory with a held request/response handshake.
module lwc_lane (
  input  logic [15:0] old_data,
  input  logic [1:0]  old_mask,
  input  logic        sel,
  input  logic [15:0] wdata,
  input  logic [1:0]  wmask,
  output logic [15:0] new_data,
  output logic [1:0]  new_mask
);
  always_comb begin
    new_data = old_data;
    new_mask = old_mask;
    if (sel && wmask[0]) begin
      new_data[7:0] = wdata[7:0];
      new_mask[0]   = 1'b1;
    end
    if (sel && wmask[1]) begin
      new_data[15:8] = wdata[15:8];
      new_mask[1]    = 1'b1;
    end
  end
endmodule

module line_write_combiner #(
  parameter bit AUTO_FLUSH = 1'b1,
  parameter int TAG_W      = 12
) (
  input logic clk,
  input logic reset_n,
  line_write_combiner_if.slave bus
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 16;

  typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;

  state_t state, state_nxt;
  logic [TAG_W-1:0]                    tag;
  logic [NUM_LANES-1:0][VEC_W-1:0]     line, base_line, merged_line;
  logic [NUM_LANES-1:0][1:0]           mask, base_mask, merged_mask;
  logic                                hit, accept, done;

  assign hit = (state == HOLD) && (bus.cpu_addr[15 -: TAG_W] == tag);

  // A fresh line starts from all-zero data and no valid bytes.
  assign base_line = (state == EMPTY) ? '0 : line;
  assign base_mask = (state == EMPTY) ? '0 : mask;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lwc_lane u_lane (
      .old_data (base_line[g]),
      .old_mask (base_mask[g]),
      .sel      (bus.cpu_addr[3:1] == 3'(g)),
      .wdata    (bus.cpu_wdata),
      .wmask    (bus.cpu_wmask),
      .new_data (merged_line[g]),
      .new_mask (merged_mask[g])
    );
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      EMPTY: if (bus.cpu_write) begin
        accept    = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.cpu_write && hit) begin
          accept = 1'b1;
          if (bus.flush_req || (AUTO_FLUSH && (merged_mask == '1))) state_nxt = FLUSH;
        end else if (bus.cpu_write || bus.flush_req) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: if (bus.mem_resp) begin
        done      = 1'b1;
        state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      tag   <= '0;
      line  <= '0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        line <= merged_line;
        mask <= merged_mask;
        if (state == EMPTY) tag <= bus.cpu_addr[15 -: TAG_W];
      end
      if (done) mask <= '0;
    end
  end

  // mem_write follows the state register so an async reset drops it at once.
  assign bus.cpu_resp        = accept;
  assign bus.busy            = (state != EMPTY);
  assign bus.mem_write       = (state == FLUSH);
  assign bus.mem_address     = {tag, 4'b0000};
  assign bus.mem_wdata       = line;
  assign bus.mem_byte_enable = mask;
  assign bus.flush_done      = done;
endmodule

// File: tb/tb_line_write_combiner.sv
// Directed table, corner sequences and a randomized run against a byte-level model.
module tb_line_write_combiner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  line_write_combiner_if bus ();

  line_write_combiner #(.AUTO_FLUSH(1'b1), .TAG_W(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wmask = '0;
    bus.flush_req = 1'b0;
    bus.mem_resp  = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    bus.cpu_write = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_wmask = m;
  endtask

  task automatic mem_ack();
    @(negedge clk);
    bus.mem_resp = 1'b1;
    #1 chk("ack_flush_done", bus.flush_done, 1);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1 chk("ack_idle", bus.busy, 0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic [15:0] exp_mask;
    int          lane;
    logic [15:0] exp_lane;
  } vec_t;

  vec_t tbl[4];

  // reference model: bytes of the line, their valid flags, and flags for line held / draining
  logic [7:0]  mb[16];
  logic [15:0] mv;
  logic [11:0] mtag;
  bit          have, drain, pend;

  task automatic model_merge(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    int b;
    b = int'(a[3:1]) * 2;
    if (m[0]) begin mb[b]   = d[7:0];  mv[b]   = 1'b1; end
    if (m[1]) begin mb[b+1] = d[15:8]; mv[b+1] = 1'b1; end
  endtask

  initial begin
    logic [127:0] exp_line;
    logic e_resp;
    idle();

    // reset state
    #12;
    chk("rst_cpu_resp", bus.cpu_resp, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_be", bus.mem_byte_enable, 0);
    chk("rst_flush_done", bus.flush_done, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // merge table: placement, partial bytes, overwrite
    tbl[0] = '{16'h1006, 16'hBEEF, 2'b11, 16'h00C0, 3, 16'hBEEF};
    tbl[1] = '{16'h1001, 16'h12AB, 2'b01, 16'h00C1, 0, 16'h00AB};
    tbl[2] = '{16'h100E, 16'h7788, 2'b10, 16'h80C1, 7, 16'h7700};
    tbl[3] = '{16'h1006, 16'hCAFE, 2'b01, 16'h80C1, 3, 16'hBEFE};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      store(tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
      #1 chk($sformatf("tbl%0d_resp", i), bus.cpu_resp, 1);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_busy", i), bus.busy, 1);
      chk($sformatf("tbl%0d_mask", i), bus.mem_byte_enable, tbl[i].exp_mask);
      chk($sformatf("tbl%0d_lane", i), bus.mem_wdata[tbl[i].lane*16 +: 16], tbl[i].exp_lane);
    end

    // miss drains old line, store accepted after drain
    @(negedge clk);
    store(16'h2000, 16'h1234, 2'b11);
    #1 chk("miss_resp", bus.cpu_resp, 0);
    exp_line = 128'h7700_0000_0000_0000_BEFE_0000_0000_00AB;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      #1;
      chk("miss_mem_write", bus.mem_write, 1);
      chk("miss_addr", bus.mem_address, 16'h1000);
      chk("miss_be", bus.mem_byte_enable, 16'h80C1);
      chk("miss_wdata", bus.mem_wdata, exp_line);
      chk("miss_wait_resp", bus.cpu_resp, 0);
    end
    @(negedge clk);
    bus.mem_resp = 1'b1;
    #1;
    chk("miss_flush_done", bus.flush_done, 1);
    chk("miss_resp_on_ack", bus.cpu_resp, 0);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    chk("miss_late_accept", bus.cpu_resp, 1);
    chk("miss_done_pulse", bus.flush_done, 0);
    chk("miss_mw_low", bus.mem_write, 0);
    @(posedge clk);
    #1;
    chk("miss_new_tag", bus.mem_address, 16'h2000);
    chk("miss_new_be", bus.mem_byte_enable, 16'h0003);
    @(negedge clk);
    bus.cpu_write = 1'b0;
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    #1 chk("freq_mem_write", bus.mem_write, 1);
    mem_ack();

    // auto flush once every byte is valid
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      store(16'h3000 + 16'(2*i), 16'(i), 2'b11);
      #1 chk($sformatf("auto%0d_resp", i), bus.cpu_resp, 1);
    end
    @(negedge clk);
    bus.cpu_write = 1'b0;
    #1;
    chk("auto_mem_write", bus.mem_write, 1);
    chk("auto_be", bus.mem_byte_enable, 16'hFFFF);
    chk("auto_wdata", bus.mem_wdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    mem_ack();

    // flush_req together with a hitting store
    @(negedge clk);
    store(16'h4002, 16'hAAAA, 2'b11);
    @(negedge clk);
    store(16'h4004, 16'hBBBB, 2'b11);
    bus.flush_req = 1'b1;
    #1 chk("fh_resp", bus.cpu_resp, 1);
    @(negedge clk);
    bus.cpu_write = 1'b0;
    bus.flush_req = 1'b0;
    #1;
    chk("fh_mem_write", bus.mem_write, 1);
    chk("fh_be", bus.mem_byte_enable, 16'h003C);
    chk("fh_wdata", bus.mem_wdata[47:16], 32'hBBBB_AAAA);
    mem_ack();

    // flush_req while empty does nothing
    @(negedge clk);
    bus.flush_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("fe_mem_write", bus.mem_write, 0);
      chk("fe_busy", bus.busy, 0);
    end
    bus.flush_req = 1'b0;

    // reset while flushing
    @(negedge clk);
    store(16'h5000, 16'h0101, 2'b11);
    @(negedge clk);
    bus.cpu_write = 1'b0;
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    #1 chk("rf_mem_write", bus.mem_write, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rf_abort_mw", bus.mem_write, 0);
    chk("rf_abort_busy", bus.busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.mem_resp = 1'b1;
    #1;
    chk("rf_late_done", bus.flush_done, 0);
    chk("rf_late_mw", bus.mem_write, 0);
    @(negedge clk);
    bus.mem_resp = 1'b0;

    // randomized run against the byte model
    mv = '0; have = 0; drain = 0; pend = 0; mtag = '0;
    for (int b = 0; b < 16; b++) mb[b] = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (!pend && $urandom_range(2) == 0) begin
        pend = 1;
        store({12'h060 + 12'($urandom_range(1)), 4'($urandom)}, 16'($urandom),
              2'($urandom_range(3, 1)));
      end
      bus.cpu_write = pend;
      bus.flush_req = ($urandom_range(7) == 0);
      bus.mem_resp  = ($urandom_range(2) == 0);
      #1;
      e_resp = pend && !drain && (!have || bus.cpu_addr[15:4] == mtag);
      chk("rnd_resp", bus.cpu_resp, e_resp);
      chk("rnd_busy", bus.busy, have || drain);
      chk("rnd_mem_write", bus.mem_write, drain);
      chk("rnd_flush_done", bus.flush_done, drain && bus.mem_resp);
      if (drain) begin
        for (int b = 0; b < 16; b++) exp_line[b*8 +: 8] = mb[b];
        chk("rnd_addr", bus.mem_address, {mtag, 4'b0000});
        chk("rnd_be", bus.mem_byte_enable, mv);
        chk("rnd_wdata", bus.mem_wdata, exp_line);
      end
      if (drain) begin
        if (bus.mem_resp) begin drain = 0; have = 0; mv = '0; end
      end else if (have) begin
        if (e_resp) begin
          model_merge(bus.cpu_addr, bus.cpu_wdata, bus.cpu_wmask);
          if (bus.flush_req || mv == 16'hFFFF) drain = 1;
        end else if (pend || bus.flush_req) begin
          drain = 1;
        end
      end else if (pend) begin
        for (int b = 0; b < 16; b++) mb[b] = '0;
        mv = '0;
        mtag = bus.cpu_addr[15:4];
        have = 1;
        model_merge(bus.cpu_addr, bus.cpu_wdata, bus.cpu_wmask);
      end
      if (e_resp) pend = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
